// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM states, forward-select codes
// and the forward-select width derivation.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LSU_WAIT   = 2'd1,
        ST_REDIR_PEND = 2'd2
    } state_e;

    localparam int FWD_RF = 0;

    function automatic int fwd_width(input int lanes);
        return $clog2(2 * lanes + 1);
    endfunction

    function automatic int fwd_ex_code(input int lane);
        return 1 + lane;
    endfunction

    function automatic int fwd_wb_code(input int lanes, input int lane);
        return lanes + 1 + lane;
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forward-select for one decode source against all ex/wb destinations; purely combinational.
// Code 0 = regfile, otherwise the youngest (ex before wb), highest-lane matching writer.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int LANES = 2,
    parameter int RAW   = 5,
    parameter int FW    = 3
) (
    input  logic [RAW-1:0]       src,
    input  logic [LANES*RAW-1:0] ex_rd,
    input  logic [LANES-1:0]     ex_we,
    input  logic [LANES*RAW-1:0] wb_rd,
    input  logic [LANES-1:0]     wb_we,
    output logic [FW-1:0]        sel
);

    always_comb begin
        sel = FW'(FWD_RF);
        if (src != '0) begin
            // Later assignments override, so ex (applied last) beats wb and higher lanes win.
            for (int k = 0; k < LANES; k++) begin
                if (wb_we[k] && (wb_rd[k*RAW +: RAW] == src)) begin
                    sel = FW'(fwd_wb_code(LANES, k));
                end
            end
            for (int k = 0; k < LANES; k++) begin
                if (ex_we[k] && (ex_rd[k*RAW +: RAW] == src)) begin
                    sel = FW'(fwd_ex_code(k));
                end
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: forwarding selects (comb), load-use bubble, LSU stall FSM
// and redirect arbitration; all control outputs registered (one cycle after the causing inputs).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int  LANES = 2,
    parameter int  XLEN  = 32,
    parameter int  RAW   = 5,
    localparam int FW    = fwd_width(LANES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_full,
    input  logic                  buffer_full,
    input  logic [LANES-1:0]      br_valid,
    input  logic [LANES*XLEN-1:0] br_addr,
    input  logic                  jal_valid,
    input  logic [XLEN-1:0]       jal_addr,
    input  logic [LANES*RAW-1:0]  dec_rs1,
    input  logic [LANES*RAW-1:0]  dec_rs2,
    input  logic [LANES-1:0]      dec_valid,
    input  logic [LANES*RAW-1:0]  ex_rd,
    input  logic [LANES*RAW-1:0]  wb_rd,
    input  logic [LANES-1:0]      ex_we,
    input  logic [LANES-1:0]      wb_we,
    input  logic [LANES-1:0]      ex_load,
    input  logic                  lsu_busy,
    input  logic                  lsu_done,
    output logic                  stop_fetch,
    output logic                  fifo_stall,
    output logic                  stall_fe,
    output logic                  stall_de,
    output logic                  stall_ex,
    output logic                  redir_valid,
    output logic [XLEN-1:0]       redir_addr,
    output logic                  flush_fe,
    output logic                  flush_de,
    output logic [LANES-1:0]      kill_de,
    output logic [LANES*FW-1:0]   fwd_sel1,
    output logic [LANES*FW-1:0]   fwd_sel2,
    output logic                  bubble_ex
);

    for (genvar g = 0; g < LANES; g++) begin : g_fwd
        pipe_fwd_unit #(.LANES(LANES), .RAW(RAW), .FW(FW)) u_fwd1 (
            .src   (dec_rs1[g*RAW +: RAW]),
            .ex_rd (ex_rd),
            .ex_we (ex_we),
            .wb_rd (wb_rd),
            .wb_we (wb_we),
            .sel   (fwd_sel1[g*FW +: FW])
        );
        pipe_fwd_unit #(.LANES(LANES), .RAW(RAW), .FW(FW)) u_fwd2 (
            .src   (dec_rs2[g*RAW +: RAW]),
            .ex_rd (ex_rd),
            .ex_we (ex_we),
            .wb_rd (wb_rd),
            .wb_we (wb_we),
            .sel   (fwd_sel2[g*FW +: FW])
        );
    end

    state_e            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_br_q, pend_br_d;
    logic [XLEN-1:0]   pend_addr_q, pend_addr_d;
    logic [LANES-1:0]  pend_kill_q, pend_kill_d;

    logic              stop_fetch_q, stop_fetch_d;
    logic              fifo_stall_q, fifo_stall_d;
    logic              stall_fe_q, stall_fe_d;
    logic              stall_de_q, stall_de_d;
    logic              stall_ex_q, stall_ex_d;
    logic              redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]   redir_addr_q, redir_addr_d;
    logic              flush_fe_q, flush_fe_d;
    logic              flush_de_q, flush_de_d;
    logic [LANES-1:0]  kill_de_q, kill_de_d;
    logic              bubble_ex_q, bubble_ex_d;

    logic              req_vld, req_br, req_found;
    logic [XLEN-1:0]   req_addr;
    logic [LANES-1:0]  req_kill;
    logic              load_use;
    logic              lu_stall;
    logic              wait_d;

    // Lowest resolved branch lane wins; younger lanes above it are killed in decode.
    always_comb begin
        req_vld   = 1'b0;
        req_br    = 1'b0;
        req_found = 1'b0;
        req_addr  = '0;
        req_kill  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (br_valid[k] && !req_found) begin
                req_found = 1'b1;
                req_vld   = 1'b1;
                req_br    = 1'b1;
                req_addr  = br_addr[k*XLEN +: XLEN];
                for (int j = 0; j < LANES; j++) begin
                    req_kill[j] = (j > k);
                end
            end
        end
        if (!req_found && jal_valid) begin
            req_vld  = 1'b1;
            req_addr = jal_addr;
        end
    end

    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < LANES; j++) begin
                if (ex_load[k] && ex_we[k] && (ex_rd[k*RAW +: RAW] != '0) && dec_valid[j] &&
                    ((dec_rs1[j*RAW +: RAW] == ex_rd[k*RAW +: RAW]) ||
                     (dec_rs2[j*RAW +: RAW] == ex_rd[k*RAW +: RAW]))) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_vld_d    = pend_vld_q;
        pend_br_d     = pend_br_q;
        pend_addr_d   = pend_addr_q;
        pend_kill_d   = pend_kill_q;
        redir_valid_d = 1'b0;
        redir_addr_d  = '0;
        flush_fe_d    = 1'b0;
        flush_de_d    = 1'b0;
        kill_de_d     = '0;
        bubble_ex_d   = 1'b0;
        lu_stall      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A redirect flushes the dependent instruction, so it suppresses the bubble.
                if (req_vld) begin
                    redir_valid_d = 1'b1;
                    redir_addr_d  = req_addr;
                    flush_fe_d    = 1'b1;
                    flush_de_d    = req_br;
                    kill_de_d     = req_kill;
                end else if (load_use) begin
                    bubble_ex_d = 1'b1;
                    lu_stall    = 1'b1;
                end
                if (lsu_busy && !lsu_done) begin
                    state_d = ST_LSU_WAIT;
                end
            end
            ST_LSU_WAIT: begin
                if (!pend_vld_q && req_vld) begin
                    pend_vld_d  = 1'b1;
                    pend_br_d   = req_br;
                    pend_addr_d = req_addr;
                    pend_kill_d = req_kill;
                end
                if (lsu_done) begin
                    if (pend_vld_d) begin
                        redir_valid_d = 1'b1;
                        redir_addr_d  = pend_addr_d;
                        flush_fe_d    = 1'b1;
                        flush_de_d    = pend_br_d;
                        kill_de_d     = pend_kill_d;
                        state_d       = ST_REDIR_PEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    pend_vld_d = 1'b0;
                end
            end
            // The pending redirect is on the outputs this cycle; everything younger is flushed.
            ST_REDIR_PEND: state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase

        wait_d       = (state_d == ST_LSU_WAIT);
        stall_fe_d   = wait_d | lu_stall;
        stall_de_d   = wait_d | lu_stall;
        stall_ex_d   = wait_d;
        stop_fetch_d = fifo_full;
        fifo_stall_d = buffer_full | wait_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pend_vld_q    <= 1'b0;
            pend_br_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_kill_q   <= '0;
            stop_fetch_q  <= 1'b0;
            fifo_stall_q  <= 1'b0;
            stall_fe_q    <= 1'b0;
            stall_de_q    <= 1'b0;
            stall_ex_q    <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_addr_q  <= '0;
            flush_fe_q    <= 1'b0;
            flush_de_q    <= 1'b0;
            kill_de_q     <= '0;
            bubble_ex_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_vld_q    <= pend_vld_d;
            pend_br_q     <= pend_br_d;
            pend_addr_q   <= pend_addr_d;
            pend_kill_q   <= pend_kill_d;
            stop_fetch_q  <= stop_fetch_d;
            fifo_stall_q  <= fifo_stall_d;
            stall_fe_q    <= stall_fe_d;
            stall_de_q    <= stall_de_d;
            stall_ex_q    <= stall_ex_d;
            redir_valid_q <= redir_valid_d;
            redir_addr_q  <= redir_addr_d;
            flush_fe_q    <= flush_fe_d;
            flush_de_q    <= flush_de_d;
            kill_de_q     <= kill_de_d;
            bubble_ex_q   <= bubble_ex_d;
        end
    end

    assign stop_fetch  = stop_fetch_q;
    assign fifo_stall  = fifo_stall_q;
    assign stall_fe    = stall_fe_q;
    assign stall_de    = stall_de_q;
    assign stall_ex    = stall_ex_q;
    assign redir_valid = redir_valid_q;
    assign redir_addr  = redir_addr_q;
    assign flush_fe    = flush_fe_q;
    assign flush_de    = flush_de_q;
    assign kill_de     = kill_de_q;
    assign bubble_ex   = bubble_ex_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a behavioural model, plus directed literal scenarios.
module tb_pipe_ctrl;
    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int FW    = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic fifo_full, buffer_full, jal_valid, lsu_busy, lsu_done;
    logic [LANES-1:0] br_valid, dec_valid, ex_we, wb_we, ex_load;
    logic [LANES*XLEN-1:0] br_addr;
    logic [XLEN-1:0] jal_addr;
    logic [LANES*RAW-1:0] dec_rs1, dec_rs2, ex_rd, wb_rd;
    logic stop_fetch, fifo_stall, stall_fe, stall_de, stall_ex;
    logic redir_valid, flush_fe, flush_de, bubble_ex;
    logic [XLEN-1:0] redir_addr;
    logic [LANES-1:0] kill_de;
    logic [LANES*FW-1:0] fwd_sel1, fwd_sel2;

    pipe_ctrl #(.LANES(LANES), .XLEN(XLEN), .RAW(RAW)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_full(fifo_full), .buffer_full(buffer_full),
        .br_valid(br_valid), .br_addr(br_addr), .jal_valid(jal_valid), .jal_addr(jal_addr),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_valid(dec_valid),
        .ex_rd(ex_rd), .wb_rd(wb_rd), .ex_we(ex_we), .wb_we(wb_we), .ex_load(ex_load),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done),
        .stop_fetch(stop_fetch), .fifo_stall(fifo_stall), .stall_fe(stall_fe),
        .stall_de(stall_de), .stall_ex(stall_ex), .redir_valid(redir_valid),
        .redir_addr(redir_addr), .flush_fe(flush_fe), .flush_de(flush_de), .kill_de(kill_de),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .bubble_ex(bubble_ex)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miscmp = 0;

    // Model: "waiting on LSU", "redirect just released after LSU", and the held redirect.
    bit m_wait, m_after, m_pv, m_pbr;
    logic [XLEN-1:0] m_pa;
    logic [LANES-1:0] m_pk;
    logic e_stop, e_fst, e_sfe, e_sde, e_sex, e_rv, e_ffe, e_fde, e_bub;
    logic [XLEN-1:0] e_ra;
    logic [LANES-1:0] e_kill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input logic [RAW-1:0] s);
        if (s == 0) return 0;
        for (int k = LANES - 1; k >= 0; k--)
            if (ex_we[k] && ex_rd[k*RAW +: RAW] == s) return k + 1;
        for (int k = LANES - 1; k >= 0; k--)
            if (wb_we[k] && wb_rd[k*RAW +: RAW] == s) return LANES + 1 + k;
        return 0;
    endfunction

    task automatic model_clear();
        e_stop = 0; e_fst = 0; e_sfe = 0; e_sde = 0; e_sex = 0;
        e_rv = 0; e_ra = '0; e_ffe = 0; e_fde = 0; e_kill = '0; e_bub = 0;
    endtask

    task automatic model_issue(input logic [XLEN-1:0] a, input bit br, input logic [LANES-1:0] k);
        e_rv = 1; e_ra = a; e_ffe = 1; e_fde = br; e_kill = k;
    endtask

    // Expected registered outputs after the coming rising edge, from the inputs now applied.
    task automatic model_step();
        bit rq, rbr, lu;
        logic [XLEN-1:0] ra;
        logic [LANES-1:0] rk;
        int win;
        model_clear();
        if (!rst_n) begin
            m_wait = 0; m_after = 0; m_pv = 0;
            return;
        end
        e_stop = fifo_full;
        win = -1;
        for (int k = LANES - 1; k >= 0; k--) if (br_valid[k]) win = k;
        rq = 0; rbr = 0; ra = '0; rk = '0;
        if (win >= 0) begin
            rq = 1; rbr = 1; ra = br_addr[win*XLEN +: XLEN];
            for (int k = win + 1; k < LANES; k++) rk[k] = 1'b1;
        end else if (jal_valid) begin
            rq = 1; ra = jal_addr;
        end
        lu = 0;
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < LANES; j++)
                if (ex_load[k] && ex_we[k] && ex_rd[k*RAW +: RAW] != 0 && dec_valid[j] &&
                    (dec_rs1[j*RAW +: RAW] == ex_rd[k*RAW +: RAW] ||
                     dec_rs2[j*RAW +: RAW] == ex_rd[k*RAW +: RAW])) lu = 1;
        if (m_after) begin
            m_after = 0;
        end else if (!m_wait) begin
            if (rq) model_issue(ra, rbr, rk);
            else if (lu) begin e_bub = 1; e_sfe = 1; e_sde = 1; end
            if (lsu_busy && !lsu_done) m_wait = 1;
        end else begin
            if (!m_pv && rq) begin m_pv = 1; m_pa = ra; m_pbr = rbr; m_pk = rk; end
            if (lsu_done) begin
                m_wait = 0;
                if (m_pv) begin model_issue(m_pa, m_pbr, m_pk); m_after = 1; end
                m_pv = 0;
            end
        end
        if (m_wait) begin e_sfe = 1; e_sde = 1; e_sex = 1; end
        e_fst = buffer_full | m_wait;
    endtask

    task automatic check_fwd();
        for (int j = 0; j < LANES; j++) begin
            chk($sformatf("fwd_sel1[%0d]", j), 32'(fwd_sel1[j*FW +: FW]), ref_fwd(dec_rs1[j*RAW +: RAW]));
            chk($sformatf("fwd_sel2[%0d]", j), 32'(fwd_sel2[j*FW +: FW]), ref_fwd(dec_rs2[j*RAW +: RAW]));
        end
    endtask

    task automatic check_regs();
        chk("stop_fetch", stop_fetch, e_stop);
        chk("fifo_stall", fifo_stall, e_fst);
        chk("stall_fe", stall_fe, e_sfe);
        chk("stall_de", stall_de, e_sde);
        chk("stall_ex", stall_ex, e_sex);
        chk("redir_valid", redir_valid, e_rv);
        chk("redir_addr", redir_addr, e_ra);
        chk("flush_fe", flush_fe, e_ffe);
        chk("flush_de", flush_de, e_fde);
        chk("kill_de", 32'(kill_de), 32'(e_kill));
        chk("bubble_ex", bubble_ex, e_bub);
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic cycle();
        #1;
        check_fwd();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_regs();
    endtask

    task automatic clear_inputs();
        fifo_full = 0; buffer_full = 0; jal_valid = 0; lsu_busy = 0; lsu_done = 0;
        br_valid = '0; dec_valid = '0; ex_we = '0; wb_we = '0; ex_load = '0;
        br_addr = '0; jal_addr = '0; dec_rs1 = '0; dec_rs2 = '0; ex_rd = '0; wb_rd = '0;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        m_wait = 0; m_after = 0; m_pv = 0; m_pbr = 0; m_pa = '0; m_pk = '0;
        model_clear();
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_redir_valid", redir_valid, 0);
        chk("rst_redir_addr", redir_addr, 0);
        chk("rst_stall_fe", stall_fe, 0);
        rst_n = 1;
        cycle();

        // Forwarding: ex lane1 beats wb lane0; x0 never forwards.
        dec_rs1[0 +: RAW] = 5; ex_rd[RAW +: RAW] = 5; ex_we = 2'b10;
        wb_rd[0 +: RAW] = 5; wb_we = 2'b01;
        #1 chk("fwd_ex_over_wb", 32'(fwd_sel1[0 +: FW]), 2);
        dec_rs1[0 +: RAW] = 0; ex_rd = '0; ex_we = 2'b01;
        #1 chk("fwd_x0", 32'(fwd_sel1[0 +: FW]), 0);
        cycle();
        clear_inputs();

        // Two branches plus a JAL: lane0 wins, lane1 killed.
        br_valid = 2'b11; br_addr = {32'h200, 32'h100}; jal_valid = 1; jal_addr = 32'h999;
        cycle();
        chk("br_redir_valid", redir_valid, 1);
        chk("br_redir_addr", redir_addr, 32'h100);
        chk("br_kill_de", 32'(kill_de), 2);
        chk("br_flush_de", flush_de, 1);
        clear_inputs();
        cycle();
        chk("br_pulse_end", redir_valid, 0);

        // Load-use: one bubble, gone once the hazard clears.
        ex_load = 2'b01; ex_we = 2'b01; ex_rd[0 +: RAW] = 7; dec_valid = 2'b10; dec_rs2[RAW +: RAW] = 7;
        cycle();
        chk("lu_bubble", bubble_ex, 1);
        chk("lu_stall_fe", stall_fe, 1);
        chk("lu_stall_de", stall_de, 1);
        clear_inputs();
        cycle();
        chk("lu_no_repeat", bubble_ex, 0);

        // LSU busy 4 cycles, branch lane1 during the wait.
        lsu_busy = 1;
        cycle();
        chk("lsu_stall_fe", stall_fe, 1);
        cycle();
        chk("lsu_stall_ex", stall_ex, 1);
        br_valid = 2'b10; br_addr[XLEN +: XLEN] = 32'h40;
        cycle();
        chk("lsu_no_redir", redir_valid, 0);
        br_valid = '0; lsu_done = 1;
        cycle();
        chk("lsu_redir_valid", redir_valid, 1);
        chk("lsu_redir_addr", redir_addr, 32'h40);
        chk("lsu_stall_drop", stall_fe, 0);
        lsu_busy = 0; lsu_done = 0;
        cycle();
        chk("lsu_redir_pulse", redir_valid, 0);

        // Reset while waiting with a pending redirect.
        lsu_busy = 1;
        cycle();
        br_valid = 2'b01; br_addr[0 +: XLEN] = 32'h80;
        cycle();
        rst_n = 0;
        #1;
        chk("arst_stall_fe", stall_fe, 0);
        chk("arst_fifo_stall", fifo_stall, 0);
        chk("arst_stall_ex", stall_ex, 0);
        m_wait = 0; m_after = 0; m_pv = 0;
        model_clear();
        clear_inputs();
        @(negedge clk);
        cycle();
        rst_n = 1;
        lsu_done = 1;
        cycle();
        lsu_done = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("arst_no_redir", redir_valid, 0);
        end

        for (int i = 0; i < 2500; i++) begin
            rst_n       = ($urandom_range(399) != 0);
            fifo_full   = ($urandom_range(3) == 0);
            buffer_full = ($urandom_range(3) == 0);
            for (int k = 0; k < LANES; k++) begin
                br_valid[k]  = ($urandom_range(7) == 0);
                dec_valid[k] = $urandom_range(1);
                ex_we[k]     = $urandom_range(1);
                wb_we[k]     = $urandom_range(1);
                ex_load[k]   = ($urandom_range(3) == 0);
                br_addr[k*XLEN +: XLEN] = $urandom;
                dec_rs1[k*RAW +: RAW] = RAW'($urandom_range(7));
                dec_rs2[k*RAW +: RAW] = RAW'($urandom_range(7));
                ex_rd[k*RAW +: RAW]   = RAW'($urandom_range(7));
                wb_rd[k*RAW +: RAW]   = RAW'($urandom_range(7));
            end
            jal_valid = ($urandom_range(7) == 0);
            jal_addr  = $urandom;
            lsu_busy  = ($urandom_range(2) == 0);
            lsu_done  = ($urandom_range(3) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter LANES, default 2, issue width (1..4).
REQ-002 Parameter XLEN, default 32, address width.
REQ-003 Parameter RAW, default 5, register-index width; FW = clog2(2*LANES+1) is the forward-select width.
REQ-004 One clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-005 clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-006 fifo_full  in  1  fetch FIFO full; buffer_full  in  1  issue buffer full.
REQ-007 br_valid  in  LANES  lane resolved taken branch; br_addr  in  LANES*XLEN  target per lane.
REQ-008 jal_valid  in  1  decode-time JAL; jal_addr  in  XLEN  its target.
REQ-009 dec_rs1, dec_rs2  in  LANES*RAW  decode sources; dec_valid  in  LANES.
REQ-010 ex_rd, wb_rd  in  LANES*RAW; ex_we, wb_we  in  LANES; ex_load  in  LANES  execute op is a load.
REQ-011 lsu_busy  in  1; lsu_done  in  1  LSU completes this cycle.
REQ-012 stop_fetch, fifo_stall, stall_fe, stall_de, stall_ex  out  1 each, registered.
REQ-013 redir_valid  out  1; redir_addr  out  XLEN; flush_fe, flush_de  out  1; kill_de  out  LANES; all registered.
REQ-014 fwd_sel1, fwd_sel2  out  LANES*FW  combinational; bubble_ex  out  1 registered.

Function
REQ-015 fwd code: 0 regfile, 1..LANES = ex lane k-1, LANES+1..2*LANES = wb lane k-LANES-1.
REQ-016 Match requires source nonzero, equal index, corresponding we=1; x0 never forwards.
REQ-017 Priority: any ex match over any wb match; within a stage, highest lane index wins.
REQ-018 Load-use: ex_load[k] matching a valid decode source in IDLE -> next cycle stall_fe=stall_de=1, bubble_ex=1 for exactly one cycle.
REQ-019 Redirect arbitration: lowest-index br_valid lane wins; any br over jal_valid; winner registered -> redir_valid/redir_addr one cycle later, pulse one cycle.
REQ-020 Branch redirect: flush_fe=flush_de=1 and kill_de bits set for lanes above winner, same cycle as redir_valid; jal redirect: flush_fe only, kill_de=0.
REQ-021 FSM states IDLE, LSU_WAIT, REDIR_PEND.
REQ-022 IDLE->LSU_WAIT when lsu_busy & !lsu_done; stall_fe/de/ex=1 from next cycle while in LSU_WAIT.
REQ-023 LSU_WAIT: redirect request captured into pending regs (first request kept, later ignored), no redir output.
REQ-024 LSU_WAIT on lsu_done -> REDIR_PEND if pending else IDLE; stalls drop the cycle after lsu_done.
REQ-025 REDIR_PEND issues pending redirect (one-cycle pulse, flushes per REQ-020), clears pending, -> IDLE.
REQ-026 Redirect in IDLE coincident with load-use: redirect wins, no bubble.
REQ-027 stop_fetch = registered fifo_full; fifo_stall = registered buffer_full | LSU_WAIT stall.
REQ-028 lsu_busy & lsu_done same cycle in IDLE: stay IDLE, no stall.

Reset
REQ-029 rst_n low: state IDLE, pending cleared, all registered outputs 0, redir_addr 0; release synchronous to next clk edge.
REQ-030 Reset mid-LSU_WAIT or with pending redirect discards pending.

Structure
REQ-031 pipe_ctrl_pkg holds state enum, fwd code constants, FW derivation function.
REQ-032 Sub-module pipe_fwd_unit: one source vs all ex/wb lanes -> FW code; instantiated 2*LANES times.

Verification
REQ-033 dec_rs1[0]=5, ex_rd[1]=5 ex_we[1]=1, wb_rd[0]=5 wb_we[0]=1 -> fwd_sel1[0]=2; rs=0 with ex_rd=0 -> 0.
REQ-034 br_valid=2'b11, addrs 0x100/0x200, jal_valid=1 -> next cycle redir_valid=1, addr 0x100, kill_de=2'b10, flush_de=1.
REQ-035 ex_load[0]=1 ex_rd=7, dec_rs2[1]=7 -> one-cycle bubble_ex, stall_fe/de; no repeat if hazard clears.
REQ-036 lsu_busy 4 cycles, br_valid[1] (0x40) at cycle 2 -> stalls held, redirect 0x40 one cycle after lsu_done, then IDLE.
REQ-037 rst_n asserted in LSU_WAIT with pending -> all outputs 0 immediately; after release no redirect issued.
